fp_divider: RTL and testbench
=============================

Name: fp_divider

Overview:
Iterative floating-point divider for the team's 24-bit format: bit 23 sign, bits 22:16 exponent (bias 63), bits 15:0 fraction with a hidden leading 1. It is the inverse operation of the pipelined multiply path. Restoring division yields one quotient bit per cycle. Operands enter on a valid/ready handshake. The result is held on a valid/ready handshake with saturating overflow and underflow flags.

Parameters:
EXP_BIAS, 63, exponent offset added back after subtracting the biased exponents.
QBITS, 18, quotient bits generated (1 integer + 17 fractional); fixes the iteration count.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  operand pair present
in_ready  out  1  divider idle, operands accepted this cycle if in_valid
in_a  in  24  dividend {sign, exp[6:0], frac[15:0]}
in_b  in  24  divisor, same format
out_valid  out  1  result registered and held
out_ready  in  1  consumer takes result
out_result  out  24  quotient, same format
out_overflow  out  1  result exponent exceeded 127; result saturated
out_underflow  out  1  result exponent below 0; result flushed

Behaviour:
- Clocking and reset: single clock; rst is synchronous and active-high.
- On reset: state=IDLE, out_valid=0, out_result=0, out_overflow=0, out_underflow=0, iteration counter=0.
- Reset mid-operation discards the operation; no result is produced.
- in_ready is combinational and equals (state==IDLE).
- States: IDLE -> DIV -> NORM -> DONE -> IDLE.
- IDLE: on in_valid&&in_ready, latch the following, then go to DIV with cnt=0:
  - sign = a.sign ^ b.sign
  - ma = {1,a.frac}, mb = {1,b.frac}
  - 9-bit signed e = {2'b0,a.exp} - {2'b0,b.exp} + EXP_BIAS (range -64..190)
  - remainder register = ma (18 bits), quotient register = 0
- DIV: one restoring step per clock.
  - If rem >= mb: shift 1 into q and set rem = (rem-mb)<<1.
  - Otherwise shift 0 into q and set rem = rem<<1.
  - cnt increments each step. After QBITS steps (cnt==17 step done), go to NORM.
- NORM, one cycle:
  - If q[17]==1: frac=q[16:1], e unchanged.
  - Else (q[16] is then guaranteed 1): frac=q[15:0], e=e-1.
  - Truncate; no rounding.
  - If e>127: out_overflow=1, out_result={sign,7'h7F,16'hFFFF}.
  - If e<0: out_underflow=1, out_result={sign,7'h00,16'h0000}.
  - Otherwise out_result={sign,e[6:0],frac} and both flags=0.
  - Set out_valid=1 and go to DONE.
- Latency: out_valid rises 19 clock edges after the accepting edge (18 DIV + 1 NORM).
- DONE: out_result and flags are held stable while out_valid=1.
  - When out_ready is sampled high: out_valid=0 at that edge, state=IDLE. Flags and result keep their values until the next NORM.
  - out_ready high before out_valid has no effect.
- No overlap: a new operand is accepted earliest on the cycle after the handshake completes. Throughput with out_ready tied high is one result per 21 cycles.
- The format has no zero, infinity or NaN encoding; every bit pattern is a normal number, so there is no divide-by-zero case.
- The sign is always propagated, including on saturated results.

Test Plan:
- Identity: in_a=0x3F0000 (1.0), in_b=0x3F0000 -> out_result=0x3F0000, flags 0, out_valid exactly 19 edges after accept.
- Normalise, no shift: in_a=0x408000 (3.0), in_b=0x3F8000 (1.5) -> 0x400000 (2.0). Sign: in_a=0xC08000, same in_b -> 0xC00000.
- Normalise with shift and truncation: in_a=0x3F0000, in_b=0x408000 -> 0x3D5555, flags 0.
- Overflow: in_a=0x7F0000, in_b=0x000000 -> out_overflow=1, out_result=0x7FFFFF. Negative variant: in_a=0xFF0000 -> 0xFFFFFF.
- Underflow boundary:
  - in_a=0x000000, in_b=0x3F8000 -> e=-1 -> out_underflow=1, out_result=0x000000.
  - in_a=0x000000, in_b=0x3F0000 -> e=0 -> 0x000000 with flags 0.
- Handshake and reset: hold out_ready=0 for 10 cycles after out_valid -> result stable, in_ready=0. Assert rst during DIV cycle 5 -> in_ready=1 and out_valid=0 next cycle, and no stale result appears.

Source files
------------

// File: rtl/fp_divider.sv
// rtl/fp_divider.sv - iterative restoring divider for the 24-bit {sign, exp[6:0], frac[15:0]} format
module fp_divider #(
    parameter int EXP_BIAS = 63,
    parameter int QBITS    = 18
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] in_a,
    input  logic [23:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] out_result,
    output logic        out_overflow,
    output logic        out_underflow
);

    localparam int CW = $clog2(QBITS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_next;

    logic              sign;
    logic signed [8:0] e;
    logic [16:0]       mb;
    logic [17:0]       rem;
    logic [QBITS-1:0]  q;
    logic [CW-1:0]     cnt;

    logic              accept;
    logic              div_last;
    logic              rem_ge;
    logic [17:0]       rem_sub;
    logic signed [8:0] e_norm;
    logic [15:0]       frac_norm;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;
    assign div_last = (cnt == CW'(QBITS - 1));
    assign rem_ge   = (rem >= {1'b0, mb});
    assign rem_sub  = rem - {1'b0, mb};

    // Quotient lies in [0.5, 2): either the integer bit is set or the next one is.
    assign e_norm    = q[QBITS-1] ? e : e - 9'sd1;
    assign frac_norm = q[QBITS-1] ? q[QBITS-2:QBITS-17] : q[QBITS-3:QBITS-18];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept)    state_next = DIV;
            DIV:  if (div_last)  state_next = NORM;
            NORM:                state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default:             state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sign          <= 1'b0;
            e             <= '0;
            mb            <= '0;
            rem           <= '0;
            q             <= '0;
            cnt           <= '0;
            out_valid     <= 1'b0;
            out_result    <= '0;
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sign <= in_a[23] ^ in_b[23];
                        e    <= {2'b00, in_a[22:16]} - {2'b00, in_b[22:16]} + 9'(EXP_BIAS);
                        mb   <= {1'b1, in_b[15:0]};
                        rem  <= {2'b01, in_a[15:0]};
                        q    <= '0;
                        cnt  <= '0;
                    end
                end
                DIV: begin
                    // rem stays below 2*mb, so the shifted value always fits 18 bits.
                    if (rem_ge) begin
                        q   <= {q[QBITS-2:0], 1'b1};
                        rem <= {rem_sub[16:0], 1'b0};
                    end else begin
                        q   <= {q[QBITS-2:0], 1'b0};
                        rem <= {rem[16:0], 1'b0};
                    end
                    cnt <= cnt + CW'(1);
                end
                NORM: begin
                    out_valid <= 1'b1;
                    if (e_norm > 9'sd127) begin
                        out_overflow  <= 1'b1;
                        out_underflow <= 1'b0;
                        out_result    <= {sign, 7'h7F, 16'hFFFF};
                    end else if (e_norm < 9'sd0) begin
                        out_overflow  <= 1'b0;
                        out_underflow <= 1'b1;
                        out_result    <= {sign, 7'h00, 16'h0000};
                    end else begin
                        out_overflow  <= 1'b0;
                        out_underflow <= 1'b0;
                        out_result    <= {sign, e_norm[6:0], frac_norm};
                    end
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_divider.sv
// tb/tb_fp_divider.sv - randomized and directed checks of fp_divider against an arithmetic model
module tb_fp_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_a;
    logic [23:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_result;
    logic        out_overflow;
    logic        out_underflow;

    int checks = 0;
    int errors = 0;

    fp_divider dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_a          (in_a),
        .in_b          (in_b),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_overflow  (out_overflow),
        .out_underflow (out_underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns {overflow, underflow, result} from the real quotient a/b.
    function automatic logic [25:0] model(input logic [23:0] a, input logic [23:0] b);
        int          ex;
        longint      ma, mb, qt;
        logic [15:0] fr;
        ex = int'(a[22:16]) - int'(b[22:16]) + 63;
        ma = 65536 + longint'(a[15:0]);
        mb = 65536 + longint'(b[15:0]);
        qt = (ma * 131072) / mb;
        if (qt >= 131072) begin
            fr = 16'((qt / 2) % 65536);
        end else begin
            fr = 16'(qt % 65536);
            ex = ex - 1;
        end
        if (ex > 127)    return {2'b10, a[23] ^ b[23], 23'h7FFFFF};
        else if (ex < 0) return {2'b01, a[23] ^ b[23], 23'h000000};
        else             return {2'b00, a[23] ^ b[23], 7'(ex), fr};
    endfunction

    task automatic run_op(input logic [23:0] a, input logic [23:0] b,
                          input bit early_ready, input int hold);
        logic [25:0] exp_v;
        int          lat;
        exp_v = model(a, b);
        check("in_ready_before", 32'(in_ready), 32'd1);
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (early_ready) out_ready = 1'b1;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 32'(lat), 32'd19);
        check("result", 32'(out_result), 32'(exp_v[23:0]));
        check("overflow", 32'(out_overflow), 32'(exp_v[25]));
        check("underflow", 32'(out_underflow), 32'(exp_v[24]));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_result", 32'(out_result), 32'(exp_v[23:0]));
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("valid_dropped", 32'(out_valid), 32'd0);
        check("in_ready_after", 32'(in_ready), 32'd1);
        check("result_kept", 32'(out_result), 32'(exp_v[23:0]));
    endtask

    initial begin
        logic [23:0] ra, rb;
        int          seen;
        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(out_result), 32'd0);
        check("rst_flags", 32'({out_overflow, out_underflow}), 32'd0);
        rst = 1'b0;

        run_op(24'h3F0000, 24'h3F0000, 1'b0, 0);
        run_op(24'h408000, 24'h3F8000, 1'b1, 0);
        run_op(24'hC08000, 24'h3F8000, 1'b0, 0);
        run_op(24'h3F0000, 24'h408000, 1'b0, 10);
        run_op(24'h7F0000, 24'h000000, 1'b0, 0);
        run_op(24'hFF0000, 24'h000000, 1'b1, 0);
        run_op(24'h000000, 24'h3F8000, 1'b0, 0);
        run_op(24'h000000, 24'h3F0000, 1'b0, 0);
        run_op(24'h7FFFFF, 24'h80FFFF, 1'b0, 0);

        for (int n = 0; n < 40; n++) begin
            ra = 24'($urandom);
            rb = 24'($urandom);
            run_op(ra, rb, 1'($urandom_range(0, 1)), 0);
        end

        // Reset during the fifth divide step abandons the operation.
        in_a = 24'h408000;
        in_b = 24'h3F8000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_result", 32'(out_result), 32'd0);
        seen = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) seen++;
        end
        out_ready = 1'b0;
        check("midrst_no_stale", 32'(seen), 32'd0);
        check("midrst_idle", 32'(in_ready), 32'd1);

        run_op(24'h3F0000, 24'h408000, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
